// File: rtl/contador_palabras.sv
// rtl/contador_palabras.sv - per-FIFO and total pop counters with registered indexed read port
module contador_palabras #(
  parameter int CNT_W  = 5,
  parameter int N_FIFO = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              init,
  input  logic              idle,
  input  logic [N_FIFO-1:0] pop_fifo_azules,
  input  logic [N_FIFO-1:0] empty_fifo_azules,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [CNT_W-1:0]  data,
  output logic              valid
);

  // Entries 0..N_FIFO-1 are per-FIFO counters, entry N_FIFO is the running total.
  logic [N_FIFO:0][CNT_W-1:0] cnt;
  logic [N_FIFO-1:0]          eff_pop;
  logic [CNT_W-1:0]           pop_sum;
  logic                       read_ok;

  assign eff_pop = pop_fifo_azules & ~empty_fifo_azules;
  assign read_ok = req & idle & (idx <= 3'(N_FIFO));

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < N_FIFO; i++) begin
      pop_sum = pop_sum + CNT_W'(eff_pop[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (Enable) begin
      if (init) begin
        cnt <= '0;
      end else begin
        for (int i = 0; i < N_FIFO; i++) begin
          cnt[i] <= cnt[i] + CNT_W'(eff_pop[i]);
        end
        cnt[N_FIFO] <= cnt[N_FIFO] + pop_sum;
      end
    end
  end

  // Reads sample the pre-update counter, so a same-edge pop or init is not yet visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (Enable && read_ok) begin
      valid <= 1'b1;
      data  <= cnt[idx];
    end else begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: tb/tb_contador_palabras.sv
// tb/tb_contador_palabras.sv - table, directed and random checks of contador_palabras
module tb_contador_palabras;
  logic       clk = 1'b0;
  logic       reset;
  logic       Enable;
  logic       init;
  logic       idle;
  logic [3:0] pop_fifo_azules;
  logic [3:0] empty_fifo_azules;
  logic       req;
  logic [2:0] idx;
  logic [4:0] data;
  logic       valid;

  int vectors = 0;
  int miscompares = 0;
  int m [4];

  typedef struct {
    logic       en;
    logic       ini;
    logic       idl;
    logic [3:0] pop;
    logic [3:0] emp;
    logic       rq;
    logic [2:0] ix;
    logic       ev;
    logic [4:0] ed;
  } vec_t;

  vec_t tbl [12];

  contador_palabras #(.CNT_W(5), .N_FIFO(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .Enable            (Enable),
    .init              (init),
    .idle              (idle),
    .pop_fifo_azules   (pop_fifo_azules),
    .empty_fifo_azules (empty_fifo_azules),
    .req               (req),
    .idx               (idx),
    .data              (data),
    .valid             (valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic ini, input logic idl, input logic [3:0] pop,
                       input logic [3:0] emp, input logic rq, input logic [2:0] ix);
    Enable = en; init = ini; idle = idl;
    pop_fifo_azules = pop; empty_fifo_azules = emp;
    req = rq; idx = ix;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
  endtask

  // Expected read result for the current inputs, then advance the counts one cycle.
  task automatic model_cycle(output logic ev, output logic [4:0] ed);
    int s;
    ev = 1'b0;
    ed = 5'd0;
    if (Enable && req && idle && idx <= 3'd4) begin
      s = 0;
      if (idx == 3'd4) begin
        for (int i = 0; i < 4; i++) s += m[i];
      end else begin
        s = m[int'(idx)];
      end
      ev = 1'b1;
      ed = 5'(s % 32);
    end
    if (Enable) begin
      for (int i = 0; i < 4; i++) begin
        if (init) m[i] = 0;
        else if (pop_fifo_azules[i] && !empty_fifo_azules[i]) m[i] = m[i] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [4:0] ed);
    vectors++;
    if (valid !== ev || data !== ed) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b data=%0d, expected valid=%0b data=%0d", name, valid, data, ev, ed);
    end
  endtask

  task automatic step(input string name);
    logic       ev;
    logic [4:0] ed;
    model_cycle(ev, ed);
    tick();
    check(name, ev, ed);
  endtask

  task automatic read_const(input logic [2:0] ix, input logic [4:0] e);
    logic       ev;
    logic [4:0] ed;
    drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, ix);
    model_cycle(ev, ed);
    tick();
    check($sformatf("read_idx%0d", ix), 1'b1, e);
  endtask

  task automatic pops(input logic [3:0] p, input logic [3:0] e, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b1, p, e, 1'b0, 3'd0);
      step("pop_cycle");
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 3'd0, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b1, 5'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b1, 5'd2};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd4, 1'b1, 5'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'b1111, 4'b0100, 1'b1, 3'd4, 1'b1, 5'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd4, 1'b1, 5'd5};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd2, 1'b1, 5'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd6, 1'b0, 5'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 3'd0, 1'b0, 5'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 3'd0, 1'b1, 5'd3};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd4, 1'b1, 5'd0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
    model_reset();
    #12;
    check("reset_state", 1'b0, 5'd0);
    reset = 1'b1;
    #5;

    for (int i = 0; i < 5; i++) read_const(3'(i), 5'd0);

    for (int i = 0; i < 12; i++) begin
      logic       ev;
      logic [4:0] ed;
      drive(tbl[i].en, tbl[i].ini, tbl[i].idl, tbl[i].pop, tbl[i].emp, tbl[i].rq, tbl[i].ix);
      model_cycle(ev, ed);
      tick();
      check($sformatf("table_row%0d", i), tbl[i].ev, tbl[i].ed);
    end

    for (int f = 0; f < 4; f++) pops(4'(1 << f), 4'h0, 6);
    for (int i = 0; i < 4; i++) read_const(3'(i), 5'd6);
    read_const(3'd4, 5'd24);

    pops(4'hf, 4'b0100, 3);
    read_const(3'd0, 5'd9);
    read_const(3'd1, 5'd9);
    read_const(3'd2, 5'd6);
    read_const(3'd3, 5'd9);
    read_const(3'd4, 5'd1);

    // Asynchronous reset in the middle of a held read, also held across an edge.
    drive(1'b1, 1'b0, 1'b1, 4'hf, 4'h0, 1'b1, 3'd4);
    step("pre_reset_read");
    #2 reset = 1'b0;
    #1 check("async_reset_drop", 1'b0, 5'd0);
    model_reset();
    tick();
    check("reset_held_edge", 1'b0, 5'd0);
    #3 reset = 1'b1;

    pops(4'b0010, 4'h0, 40);
    read_const(3'd1, 5'd8);
    read_const(3'd4, 5'd8);

    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 3'd1);
    step("req_not_idle");
    step("req_not_idle_2");
    drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 3'd6);
    step("idx6_invalid");
    drive(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 3'd1);
    tick();
    check("idle_rise_valid", 1'b1, 5'd8);
    model_cycle_sync: begin
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 3'd1);
      step("idle_fall_drop");
    end

    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 3'd0);
    step("init_clear");
    pops(4'hf, 4'h0, 4);
    drive(1'b1, 1'b1, 1'b1, 4'hf, 4'h0, 1'b0, 3'd0);
    step("init_with_pops");
    for (int i = 0; i < 5; i++) read_const(3'(i), 5'd0);

    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'hf, 4'h0, 1'b1, 3'(k));
      step("enable_low");
    end
    for (int i = 0; i < 5; i++) read_const(3'(i), 5'd0);
    pops(4'hf, 4'h0, 4);
    for (int i = 0; i < 4; i++) read_const(3'(i), 5'd4);
    read_const(3'd4, 5'd16);

    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
            4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_palabras.md
# contador_palabras

Word-counter stage downstream of the four output (azul) FIFOs in the transaction layer. It counts every word actually popped from each output FIFO and answers indexed read requests from the test/host side through a `req`/`idx` → `valid`/`data` handshake. Counter 4 holds the total of all four outputs. Reads are served only while the transaction-layer FSM reports `idle`.

## Interface

Parameters:
- `CNT_W`, default 5: counter width, matching `salida_contador`.
- `N_FIFO`, default 4: number of output FIFOs counted. Fixed at 4 for this design.

Ports:
- `clk`, input, 1 bit: single clock. All state changes on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `Enable`, input, 1 bit: block enable. When low, counting and reads are suppressed.
- `init`, input, 1 bit: FSM init indication. While high, all counters clear synchronously.
- `idle`, input, 1 bit: FSM idle indication. Reads are served only while it is high.
- `pop_fifo_azules`, input, 4 bits: pop strobes to output FIFOs 0–3.
- `empty_fifo_azules`, input, 4 bits: empty flags of output FIFOs 0–3.
- `req`, input, 1 bit: read request.
- `idx`, input, 3 bits: counter select. 0–3 select per-FIFO counters, 4 selects the total, 5–7 are invalid.
- `data`, output, `CNT_W` bits: counter value returned by a read.
- `valid`, output, 1 bit: qualifies `data`.

## Operation

- Effective pop: `pop_fifo_azules[i] & ~empty_fifo_azules[i]`. A pop to an empty FIFO is never counted.
- Counters 0–3: each increments by 1 on its own effective pop, modulo 2^CNT_W. The value wraps from 31 to 0 with no flag.
- Counter 4:
  - Separate register, incremented by the population count (0–4) of the effective pops in the same cycle, modulo 32.
  - Invariant: cnt4 == (cnt0+cnt1+cnt2+cnt3) mod 32 at all times.
- Priority per cycle:
  1. `reset` low
  2. `Enable` low (freeze)
  3. `init` high (clear all five counters to 0; pops in that cycle are ignored)
  4. normal counting
- Read service, evaluated each rising edge when `Enable` is high:
  - If `req`, `idle`, and `idx` ≤ 4 are all true: next cycle `valid`=1 and `data`=counter[idx]. The value is sampled pre-increment, i.e. the value before any pop in that same edge.
  - If `req` is high but `idle` is low, or `idx` is 5–7: next cycle `valid`=0 and `data`=0.
  - If `req` is low: next cycle `valid`=0 and `data`=0.
- Held `req`: a new read is served every cycle. `data` tracks the sampled counter cycle by cycle, and `idx` may change cycle to cycle.
- Reads never disturb the counters. Counting continues while reads are in flight.

## Timing

- Reset (asynchronous, `reset`=0): all counters, `data`, and `valid` go to 0 immediately. They stay 0 until the first rising edge after `reset` deasserts.
- Reset mid-read: `valid` drops asynchronously and no stale data is presented afterwards.
- Read latency: 1 cycle, from the edge sampling `req` to registered `valid`/`data`. Outputs are fully registered with no combinational path from inputs.
- Pop-to-count latency: 1 cycle. A pop sampled at edge N is visible to a read sampled at edge N+1, returned at N+2.
- `Enable` low:
  - Counters hold their value.
  - `valid` and `data` go to 0 on the next edge.
  - On re-enable, counting resumes from the held values.
- `init` high:
  - Counters read 0 from the next edge.
  - A read sampled in the same edge as `init` returns the pre-clear value, if `idle` is also high.
- `idle` falling while `req` is held: `valid` drops on the next edge after `idle` is sampled low.
- Simultaneous pops on all four FIFOs in one cycle: cnt0–3 each +1 and cnt4 +4 in the same edge.

## Test plan

- Reset and release:
  - Assert `reset`=0 mid-simulation → `valid`=0, `data`=0 immediately.
  - Release, then read `idx`=0..4 → all 0.
- Per-FIFO counting:
  - Pop FIFO0 6×, FIFO1 6×, FIFO2 6×, FIFO3 6× (non-empty), `idle`=1.
  - Read `idx`=0..3 → 6 each. `idx`=4 → 24. `valid` 1 cycle after each `req`.
- Empty qualification and simultaneous pops:
  - 3 cycles with all four pops high, FIFO2 `empty`=1 → cnt0=cnt1=cnt3=+3, cnt2 unchanged, cnt4 +9.
- Wrap-around:
  - 40 pops on FIFO1 from 0 → `idx`=1 returns 8.
  - `idx`=4 returns (previous total + 40) mod 32.
- Read gating:
  - `req`=1 with `idle`=0 → `valid`=0, `data`=0.
  - `idx`=6 with `idle`=1 → `valid`=0.
  - `idle` rises with `req` held → `valid`=1 one cycle later.
- `init` and `Enable`:
  - `init`=1 for 1 cycle after counts of 4/4/4/4 → all counters read 0.
  - `Enable`=0 with pops active for 5 cycles → counts unchanged, `valid`=0.
  - Re-enable plus 4 pops per FIFO → reads 4/4/4/4/16.
